// File: rtl/i2c_master_fsm.sv
// i2c_master_fsm: I2C initiator for one address+data write with ACK checks; define I2C_MASTER_READ_EN to add a one-byte read
module i2c_master_fsm #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] slave_addr,
  input  logic [7:0] wr_data,
`ifdef I2C_MASTER_READ_EN
  input  logic       rw,
  output logic [7:0] rd_data,
  output logic       rd_valid,
`endif
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       sclk,
  inout  wire        sda,
  output logic       sda_dir_m
);
  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP
`ifdef I2C_MASTER_READ_EN
    , RD_DATA, RD_NACK
`endif
  } state_t;
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic        tick;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        sclk_q, sclk_d;
  logic        sda_out_q, sda_out_d;
  logic        dir_q, dir_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef I2C_MASTER_READ_EN
  logic        rw_q, rw_d;
  logic [7:0]  rd_q, rd_d;
  logic        rd_valid_q, rd_valid_d;
`endif
  assign tick = (state_q != IDLE) && (cnt_q == DIV_M1);
  // quarter-period divider, held at zero while idle so the first tick lands CLK_DIV cycles after accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (state_q == IDLE || tick) cnt_q <= '0;
    else cnt_q <= cnt_q + 16'd1;
  end
  // bus sequencing: every bus change is made on a quarter tick
  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    sclk_d    = sclk_q;
    sda_out_d = sda_out_q;
    dir_d     = dir_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
`ifdef I2C_MASTER_READ_EN
    rw_d       = rw_q;
    rd_d       = rd_q;
    rd_valid_d = 1'b0;
`endif
    if (state_q == IDLE) begin
      if (start && !done_q) begin
        shift_d = {slave_addr, 1'b0};
        data_d  = wr_data;
        busy_d  = 1'b1;
        err_d   = 1'b0;
        qtr_d   = 2'd0;
        bit_d   = 3'd0;
        state_d = START;
`ifdef I2C_MASTER_READ_EN
        shift_d[0] = rw;
        rw_d       = rw;
`endif
      end
    end else if (tick) begin
      qtr_d = (state_q == START) ? 2'd0 : qtr_q + 2'd1;
      if (state_q == START) begin
        sda_out_d = 1'b0;
        state_d   = ADDR;
      end else begin
        case (qtr_q)
          2'd0: sclk_d = 1'b0;
          2'd1: begin
            case (state_q)
              ADDR, DATA: begin
                dir_d     = 1'b1;
                sda_out_d = shift_q[7];
              end
              STOP: begin
                dir_d     = 1'b1;
                sda_out_d = 1'b0;
              end
`ifdef I2C_MASTER_READ_EN
              RD_NACK: begin
                dir_d     = 1'b1;
                sda_out_d = 1'b1;
              end
`endif
              default: dir_d = 1'b0;
            endcase
          end
          2'd2: sclk_d = 1'b1;
          default: begin
            case (state_q)
              ADDR, DATA: begin
                shift_d = {shift_q[6:0], 1'b0};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
              end
              ADDR_ACK: begin
                shift_d = data_q;
                err_d   = err_q | sda;
                state_d = sda ? STOP : DATA;
`ifdef I2C_MASTER_READ_EN
                if (!sda && rw_q) state_d = RD_DATA;
`endif
              end
              DATA_ACK: begin
                err_d   = err_q | sda;
                state_d = STOP;
              end
`ifdef I2C_MASTER_READ_EN
              RD_DATA: begin
                shift_d = {shift_q[6:0], sda};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                  rd_d    = {shift_q[6:0], sda};
                  state_d = RD_NACK;
                end
              end
              RD_NACK: state_d = STOP;
`endif
              STOP: begin
                sda_out_d = 1'b1;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
`ifdef I2C_MASTER_READ_EN
                rd_valid_d = rw_q & ~err_q;
`endif
              end
              default: ;
            endcase
          end
        endcase
      end
    end
  end
  // state and bus registers; reset drops any transfer and parks the bus idle-high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      shift_q   <= '0;
      data_q    <= '0;
      sclk_q    <= 1'b1;
      sda_out_q <= 1'b1;
      dir_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      sclk_q    <= sclk_d;
      sda_out_q <= sda_out_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
`ifdef I2C_MASTER_READ_EN
  // read-side registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q       <= 1'b0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rw_q       <= rw_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  assign rd_data  = rd_q;
  assign rd_valid = rd_valid_q;
`endif
  assign sda       = dir_q ? sda_out_q : 1'bz;
  assign sda_dir_m = dir_q;
  assign sclk      = sclk_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_err   = err_q;
endmodule
